ai_i2s_clk_gen: RTL
===================

# ai_i2s_clk_gen

Bit-clock and word-select timing generator that sits directly upstream of the I2S TX block. It supplies the `sck`, `ws` and `clk_en` strobes that the TX serializer consumes. In master mode it divides the system clock to drive SCK/WS on the pins. In slave mode it synchronises externally driven SCK/WS and derives the same one-cycle strobes, so downstream logic is mode-agnostic.

## Interface
- `DIV_WIDTH`, 8, width of the SCK half-period divider
- `clk`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `enable`  in  1  block enable; low holds all state at reset values
- `master_mode`  in  1  1 = generate SCK/WS, 0 = follow `ext_sck`/`ext_ws`
- `clk_div`  in  DIV_WIDTH  SCK half-period minus 1, in `clk` cycles
- `slot_bits`  in  6  bits per channel slot; legal 16..32, otherwise treated as 16
- `ext_sck`, `ext_ws`  in  1 each  asynchronous pin inputs (slave mode)
- `sck`  out  1  bit clock (registered); driven to pin when `sck_oe`=1
- `ws`  out  1  word select (registered), 0 = left, 1 = right
- `sck_oe`, `ws_oe`  out  1 each  pad output enables = `master_mode & enable`
- `clk_en`  out  1  one-cycle pulse per SCK falling edge (TX shift strobe)
- `sample_en`  out  1  one-cycle pulse per SCK rising edge (RX sample strobe)
- `frame_start`  out  1  one-cycle pulse coinciding with the `clk_en` at which `ws` goes 1→0
- `frame_err`  out  1  sticky slave-mode WS-length error

## Operation
- Reset or `enable`=0: divider, bit counter, synchronisers and all outputs are 0, including `frame_err`.
- Effective slot width `eff_bits` = `slot_bits` if 16..32, else 16.
- `clk_div` and `eff_bits` are captured into shadow registers on the first enabled cycle and again at every `frame_start`. Mid-frame changes take effect at the next frame.
- Master mode:
  - `div_cnt` counts 0..`clk_div_s`. At the terminal count it wraps to 0 and `sck` toggles.
  - On the cycle `sck` registers 1→0, `clk_en` pulses. On the cycle `sck` registers 0→1, `sample_en` pulses.
  - `bit_cnt` (6 b) increments on each `clk_en`, wrapping at `eff_bits_s`-1.
  - On the `clk_en` where `bit_cnt` == `eff_bits_s`-1, `ws` toggles. WS therefore changes on the falling edge of the last bit of the slot: standard I2S one-bit-early alignment.
- Slave mode:
  - 2-flop synchronisers on `ext_sck` and `ext_ws`, plus one history flop for edge detection.
  - Falling edge of synchronised SCK → `clk_en`; rising edge → `sample_en`.
  - `ws` = synchronised WS sampled at each `sample_en`.
  - `bit_cnt` counts `sample_en` pulses and restarts at 0 on each `ws` change.
  - When `ws` changes and the completed slot length ≠ `eff_bits_s`, `frame_err` is set. The check is skipped for the first WS change after enable.
  - `frame_err` clears only on reset or `enable`=0.
- A change of `master_mode` while enabled restarts the block: all counters are cleared and `sck`/`ws` are forced to 0 on that cycle.
- `clk_en` and `sample_en` are never high in the same cycle.

## Timing
- Master: SCK period = 2·(`clk_div`+1) clk cycles; `clk_div`=0 gives clk/2. Frame = 2·`eff_bits` SCK periods.
- First `sck` rise occurs `clk_div`+1 cycles after `enable` rises.
- Slave: pin edge → `clk_en`/`sample_en` pulse latency is exactly 3 clk cycles. External SCK must be ≤ clk/4.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `ai_i2s_pkg` holds:
  - `I2S_MIN_BITS` = 16, `I2S_MAX_BITS` = 32
  - `i2s_mode_e` {SLAVE, MASTER}
- One natural sub-module: `ai_i2s_edge_sync`, a 2-flop synchroniser plus edge detector emitting `rise`/`fall` pulses. It is instantiated once each for SCK and WS.

## Test plan
- Master, `clk_div`=1, `slot_bits`=16: `sck` period 4 clk; `clk_en` every 4 clk; `ws` toggles every 16 `clk_en`; `frame_start` every 128 clk.
- Master, `slot_bits`=40 (illegal) → behaves as 16. Change `slot_bits` to 24 mid-frame → the current frame stays 16/16, the next frame is 24/24.
- Slave, external SCK of period 8 clk, WS toggling every 32 bits with `slot_bits`=32: `clk_en` appears 3 clk after each ext falling edge; `frame_err` stays 0.
- Slave, one slot shortened to 31 bits → `frame_err`=1 after that WS edge and remains set. `enable`=0 for 1 cycle → `frame_err`=0.
- `rst_n`=0 mid-frame: next cycle all outputs = 0. After release with `clk_div`=0, first `sck` rise occurs 1 cycle after the first enabled cycle.
- Toggle `master_mode` 1→0 while enabled: same cycle restart; `sck_oe`/`ws_oe` drop to 0 and no spurious `clk_en` is issued.

Source files
------------

// File: rtl/ai_i2s_pkg.sv
// Shared I2S definitions: slot-width limits, mode encoding and the
// slot-width legalisation helper used by the clock generator.
package ai_i2s_pkg;

  localparam logic [5:0] I2S_MIN_BITS = 6'd16;
  localparam logic [5:0] I2S_MAX_BITS = 6'd32;

  typedef enum logic {
    SLAVE  = 1'b0,
    MASTER = 1'b1
  } i2s_mode_e;

  // Out-of-range slot widths fall back to the 16-bit minimum.
  function automatic logic [5:0] eff_bits(input logic [5:0] slot_bits);
    if (slot_bits >= I2S_MIN_BITS && slot_bits <= I2S_MAX_BITS) begin
      return slot_bits;
    end
    return I2S_MIN_BITS;
  endfunction

endpackage

// File: rtl/ai_i2s_clk_gen_if.sv
// Configuration, pin and strobe bundle of the I2S clock generator.
// The generator uses the master modport; consumers use the slave modport.
interface ai_i2s_clk_gen_if #(
  parameter int DIV_WIDTH = 8
);

  logic                 enable;
  logic                 master_mode;
  logic [DIV_WIDTH-1:0] clk_div;
  logic [5:0]           slot_bits;
  logic                 ext_sck;
  logic                 ext_ws;
  logic                 sck;
  logic                 ws;
  logic                 sck_oe;
  logic                 ws_oe;
  logic                 clk_en;
  logic                 sample_en;
  logic                 frame_start;
  logic                 frame_err;

  modport master (
    input  enable, master_mode, clk_div, slot_bits, ext_sck, ext_ws,
    output sck, ws, sck_oe, ws_oe, clk_en, sample_en, frame_start, frame_err
  );

  modport slave (
    output enable, master_mode, clk_div, slot_bits, ext_sck, ext_ws,
    input  sck, ws, sck_oe, ws_oe, clk_en, sample_en, frame_start, frame_err
  );

endinterface

// File: rtl/ai_i2s_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin plus a history flop;
// rise/fall are decoded from flops only, one cycle wide each.
module ai_i2s_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic d_p0;
  logic d_p1;
  logic d_p2;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      d_p0 <= 1'b0;
      d_p1 <= 1'b0;
      d_p2 <= 1'b0;
    end else begin
      // p0/p1: metastability filter, p2: history for edge detection
      d_p0 <= d;
      d_p1 <= d_p0;
      d_p2 <= d_p1;
    end
  end

  assign level = d_p1;
  assign rise  = d_p1 & ~d_p2;
  assign fall  = ~d_p1 & d_p2;

endmodule

// File: rtl/ai_i2s_clk_gen.sv
// I2S bit-clock / word-select generator: divides clk in master mode or
// follows synchronised external pins in slave mode, emitting TX/RX strobes.
module ai_i2s_clk_gen
  import ai_i2s_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  ai_i2s_clk_gen_if.master bus
);

  localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  function automatic logic slot_len_bad(input logic [5:0] cnt, input logic [5:0] bits);
    return ({1'b0, cnt} + 7'd1) != {1'b0, bits};
  endfunction

  i2s_mode_e            mode;
  i2s_mode_e            mode_q;
  logic                 started;
  logic [DIV_WIDTH-1:0] clk_div_s;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [5:0]           eff_s;
  logic [5:0]           bit_cnt;
  logic                 sck_q;
  logic                 ws_q;
  logic                 oe_q;
  logic                 clk_en_q;
  logic                 sample_en_q;
  logic                 frame_start_q;
  logic                 frame_err_q;
  logic                 ws_seen;
  logic                 ws_fall_pend;
  logic                 sck_lvl;
  logic                 sck_rise;
  logic                 sck_fall;
  logic                 ws_lvl;
  logic                 ws_rise;
  logic                 ws_fall;
  logic                 clr;
  logic                 div_tc;
  logic                 last_bit;

  assign mode     = bus.master_mode ? MASTER : SLAVE;
  assign clr      = ~bus.enable;
  assign div_tc   = (div_cnt == clk_div_s);
  assign last_bit = (bit_cnt == eff_s - 6'd1);

  ai_i2s_edge_sync u_sck_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .d     (bus.ext_sck),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  ai_i2s_edge_sync u_ws_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .d     (bus.ext_ws),
    .level (ws_lvl),
    .rise  (ws_rise),
    .fall  (ws_fall)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !bus.enable) begin
      mode_q        <= SLAVE;
      started       <= 1'b0;
      clk_div_s     <= '0;
      div_cnt       <= '0;
      eff_s         <= '0;
      bit_cnt       <= '0;
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      oe_q          <= 1'b0;
      clk_en_q      <= 1'b0;
      sample_en_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_err_q   <= 1'b0;
      ws_seen       <= 1'b0;
      ws_fall_pend  <= 1'b0;
    end else if (!started) begin
      // First enabled cycle: load shadows, counters stay at zero.
      started       <= 1'b1;
      mode_q        <= mode;
      oe_q          <= bus.master_mode;
      clk_div_s     <= bus.clk_div;
      eff_s         <= eff_bits(bus.slot_bits);
      clk_en_q      <= 1'b0;
      sample_en_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (mode != mode_q) begin
      // Mode switch restarts timing; frame_err is deliberately kept.
      mode_q        <= mode;
      oe_q          <= bus.master_mode;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      sck_q         <= 1'b0;
      ws_q          <= 1'b0;
      clk_en_q      <= 1'b0;
      sample_en_q   <= 1'b0;
      frame_start_q <= 1'b0;
      ws_seen       <= 1'b0;
      ws_fall_pend  <= 1'b0;
    end else begin
      oe_q          <= bus.master_mode;
      clk_en_q      <= 1'b0;
      sample_en_q   <= 1'b0;
      frame_start_q <= 1'b0;
      if (mode == MASTER) begin
        if (div_tc) begin
          div_cnt <= '0;
          sck_q   <= ~sck_q;
          if (sck_q) begin
            clk_en_q <= 1'b1;
            if (last_bit) begin
              // WS flips on the falling edge of the slot's last bit.
              bit_cnt <= '0;
              ws_q    <= ~ws_q;
              if (ws_q) begin
                frame_start_q <= 1'b1;
                clk_div_s     <= bus.clk_div;
                eff_s         <= eff_bits(bus.slot_bits);
              end
            end else begin
              bit_cnt <= bit_cnt + 6'd1;
            end
          end else begin
            sample_en_q <= 1'b1;
          end
        end else begin
          div_cnt <= div_cnt + DIV_ONE;
        end
      end else begin
        sck_q       <= sck_lvl;
        clk_en_q    <= sck_fall;
        sample_en_q <= sck_rise;
        if (sck_fall) begin
          ws_fall_pend <= 1'b0;
        end else if (ws_fall) begin
          ws_fall_pend <= 1'b1;
        end else if (ws_rise) begin
          ws_fall_pend <= 1'b0;
        end
        if (sck_fall && (ws_fall || ws_fall_pend)) begin
          frame_start_q <= 1'b1;
          clk_div_s     <= bus.clk_div;
          eff_s         <= eff_bits(bus.slot_bits);
        end
        if (sck_rise) begin
          if (ws_lvl != ws_q) begin
            ws_q    <= ws_lvl;
            bit_cnt <= '0;
            ws_seen <= 1'b1;
            if (ws_seen && slot_len_bad(bit_cnt, eff_s)) begin
              frame_err_q <= 1'b1;
            end
          end else begin
            bit_cnt <= sat_inc(bit_cnt);
          end
        end
      end
    end
  end

  assign bus.sck         = sck_q;
  assign bus.ws          = ws_q;
  assign bus.sck_oe      = oe_q;
  assign bus.ws_oe       = oe_q;
  assign bus.clk_en      = clk_en_q;
  assign bus.sample_en   = sample_en_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_err   = frame_err_q;

endmodule
